mem_stage_lsu: RTL and testbench

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

---
 rtl/mem_stage_lsu_pkg.sv | 17 +
 rtl/mem_stage_lsu_align.sv | 53 +++++
 rtl/mem_stage_lsu.sv | 97 +++++++++
 tb/tb_mem_stage_lsu.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access-size encodings
// (funct3) and the request FSM state type.
package mem_stage_lsu_pkg;

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: store shift, byte enables, load extraction and
// extension, and misalignment detection for a given byte offset and size.
module lsu_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       offset,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] store_data,
  input  logic [WIDTH-1:0] load_word,
  output logic [WIDTH-1:0] store_lanes,
  output logic [3:0]       byte_en,
  output logic [WIDTH-1:0] load_result,
  output logic             misalign
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = load_word[{offset, 3'b000} +: 8];
  assign lane_half = load_word[{offset[1], 4'b0000} +: 16];

  // Unlisted funct3 codes are treated as full-word accesses.
  always_comb begin
    store_lanes = '0;
    byte_en     = 4'b0000;
    load_result = '0;
    misalign    = 1'b0;
    case (mode)
      MODE_B, MODE_BU: begin
        store_lanes = WIDTH'(store_data[7:0]) << {offset, 3'b000};
        byte_en     = 4'b0001 << offset;
        load_result = (mode == MODE_B) ? {{(WIDTH-8){lane_byte[7]}}, lane_byte}
                                       : {{(WIDTH-8){1'b0}}, lane_byte};
      end
      MODE_H, MODE_HU: begin
        misalign    = offset[0];
        store_lanes = WIDTH'(store_data[15:0]) << {offset[1], 4'b0000};
        byte_en     = 4'b0011 << {offset[1], 1'b0};
        load_result = (mode == MODE_H) ? {{(WIDTH-16){lane_half[15]}}, lane_half}
                                       : {{(WIDTH-16){1'b0}}, lane_half};
      end
      default: begin
        misalign    = (offset != 2'b00);
        store_lanes = store_data;
        byte_en     = 4'b1111;
        load_result = load_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: stalls the pipeline while a single registered
// memory request is outstanding, then returns the extended load result.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  input  logic             MemWriteM,
  input  logic             MemReadM,
  input  logic [2:0]       AddrModeM,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] ReadDataM,
  output logic             StallM,
  output logic             MisalignM
);

  lsu_state_t       state, next_state;
  logic [2:0]       mode_q;
  logic [1:0]       offset_q;
  logic             access, in_idle, issue;
  logic [1:0]       sel_offset;
  logic [2:0]       sel_mode;
  logic [WIDTH-1:0] store_lanes, load_result;
  logic [3:0]       byte_en;
  logic             misalign;

  assign access  = MemWriteM | MemReadM;
  assign in_idle = (state == IDLE);

  // Once issued, lane selection follows the captured access, not the live inputs.
  assign sel_offset = in_idle ? ALUResultM[1:0] : offset_q;
  assign sel_mode   = in_idle ? AddrModeM : mode_q;

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .offset      (sel_offset),
    .mode        (sel_mode),
    .store_data  (WriteDataM),
    .load_word   (mem_rdata),
    .store_lanes (store_lanes),
    .byte_en     (byte_en),
    .load_result (load_result),
    .misalign    (misalign)
  );

  assign issue     = in_idle & access & ~misalign;
  assign mem_req   = (state == BUSY);
  assign StallM    = rst_n & (mem_req | issue);
  assign MisalignM = rst_n & in_idle & access & misalign;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (issue) next_state = BUSY;
      BUSY:    if (mem_ready) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'b0000;
      mode_q    <= MODE_B;
      offset_q  <= 2'b00;
      ReadDataM <= '0;
    end else begin
      if (issue) begin
        mem_we    <= MemWriteM;
        mem_addr  <= {ALUResultM[WIDTH-1:2], 2'b00};
        mem_wdata <= store_lanes;
        mem_be    <= byte_en;
        mode_q    <= AddrModeM;
        offset_q  <= ALUResultM[1:0];
      end
      if (mem_req && mem_ready && !mem_we) ReadDataM <= load_result;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: a vector table of aligned and
// misaligned accesses, a load-result scoreboard, and a mid-BUSY reset sequence.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst_n;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        MemWriteM;
  logic        MemReadM;
  logic [2:0]  AddrModeM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        rd;
    logic [2:0]  mode;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_we;
    logic        exp_mis;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] sb_q[$];
  int          tests_run = 0;
  int          fail_count = 0;

  mem_stage_lsu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .AddrModeM  (AddrModeM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    ALUResultM = '0;
    WriteDataM = '0;
    MemWriteM  = 1'b0;
    MemReadM   = 1'b0;
    AddrModeM  = 3'b000;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
  endtask

  // One full access from IDLE; inputs are perturbed during BUSY/DONE to prove
  // the request was registered and DONE does not re-issue.
  task automatic applyStimulus(input vec_t v, input int idx);
    int          stalls;
    logic [31:0] exp;
    ALUResultM = v.addr;
    WriteDataM = v.wdata;
    MemWriteM  = v.wr;
    MemReadM   = v.rd;
    AddrModeM  = v.mode;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    #1;
    if (v.exp_mis) begin
      checkOutput($sformatf("v%0d misalign", idx), MisalignM, 1);
      checkOutput($sformatf("v%0d mis_stall", idx), StallM, 0);
      checkOutput($sformatf("v%0d mis_req", idx), mem_req, 0);
      tick();
      checkOutput($sformatf("v%0d mis_req_next", idx), mem_req, 0);
      checkOutput($sformatf("v%0d mis_rdata_hold", idx), ReadDataM, v.exp_rd);
    end else begin
      checkOutput($sformatf("v%0d idle_mis", idx), MisalignM, 0);
      checkOutput($sformatf("v%0d idle_stall", idx), StallM, 1);
      checkOutput($sformatf("v%0d idle_req", idx), mem_req, 0);
      sb_q.push_back(v.exp_rd);
      stalls = StallM ? 1 : 0;
      for (int k = 1; k <= v.delay; k++) begin
        tick();
        checkOutput($sformatf("v%0d busy%0d req", idx, k), mem_req, 1);
        checkOutput($sformatf("v%0d busy%0d addr", idx, k), mem_addr, {v.addr[31:2], 2'b00});
        checkOutput($sformatf("v%0d busy%0d be", idx, k), mem_be, v.exp_be);
        checkOutput($sformatf("v%0d busy%0d we", idx, k), mem_we, v.exp_we);
        checkOutput($sformatf("v%0d busy%0d wdata", idx, k), mem_wdata, v.exp_wdata);
        stalls += StallM;
        mem_rdata  = v.rdata;
        mem_ready  = (k == v.delay);
        ALUResultM = v.addr ^ 32'h0000_0F01;
        WriteDataM = ~v.wdata;
      end
      tick();
      mem_ready = 1'b0;
      mem_rdata = '0;
      checkOutput($sformatf("v%0d stall_cycles", idx), stalls, 1 + v.delay);
      checkOutput($sformatf("v%0d done_stall", idx), StallM, 0);
      checkOutput($sformatf("v%0d done_req", idx), mem_req, 0);
      if (sb_q.size() == 0) begin
        fail_count++;
        tests_run++;
        $display("[TB] FAIL v%0d scoreboard: got empty queue, expected one entry", idx);
      end else begin
        exp = sb_q.pop_front();
        checkOutput($sformatf("v%0d rdata", idx), ReadDataM, exp);
      end
    end
    clearInputs();
    tick();
    checkOutput($sformatf("v%0d after_stall", idx), StallM, 0);
    checkOutput($sformatf("v%0d after_req", idx), mem_req, 0);
    checkOutput($sformatf("v%0d after_rdata", idx), ReadDataM, v.exp_rd);
  endtask

  initial begin
    rst_n = 1'b0;
    clearInputs();

    //          addr        wdata         wr    rd    mode    rdata         dly wdata_exp     be    we    mis   rd_exp
    vecs[0]  = '{32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 3'b010, 32'h0,        1, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{32'h103, 32'h000000AB, 1'b1, 1'b0, 3'b000, 32'h0,        1, 32'hAB000000, 4'h8, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{32'h102, 32'h0,        1'b0, 1'b1, 3'b000, 32'h00800000, 1, 32'h0,        4'h4, 1'b0, 1'b0, 32'hFFFFFF80};
    vecs[3]  = '{32'h102, 32'h0,        1'b0, 1'b1, 3'b100, 32'h00800000, 1, 32'h0,        4'h4, 1'b0, 1'b0, 32'h00000080};
    vecs[4]  = '{32'h102, 32'h0,        1'b0, 1'b1, 3'b001, 32'h80011234, 3, 32'h0,        4'hC, 1'b0, 1'b0, 32'hFFFF8001};
    vecs[5]  = '{32'h101, 32'h0,        1'b0, 1'b1, 3'b010, 32'h0,        1, 32'h0,        4'h0, 1'b0, 1'b1, 32'hFFFF8001};
    vecs[6]  = '{32'h200, 32'h0,        1'b0, 1'b1, 3'b101, 32'h0000F00D, 1, 32'h0,        4'h3, 1'b0, 1'b0, 32'h0000F00D};
    vecs[7]  = '{32'h206, 32'h12345678, 1'b1, 1'b0, 3'b001, 32'h0,        1, 32'h56780000, 4'hC, 1'b1, 1'b0, 32'h0000F00D};
    vecs[8]  = '{32'h208, 32'h0,        1'b0, 1'b1, 3'b010, 32'hCAFEBABE, 2, 32'h0,        4'hF, 1'b0, 1'b0, 32'hCAFEBABE};
    vecs[9]  = '{32'h101, 32'h00005555, 1'b1, 1'b0, 3'b001, 32'h0,        1, 32'h0,        4'h0, 1'b0, 1'b1, 32'hCAFEBABE};
    vecs[10] = '{32'h30C, 32'h11223344, 1'b1, 1'b1, 3'b010, 32'h55555555, 1, 32'h11223344, 4'hF, 1'b1, 1'b0, 32'hCAFEBABE};
    vecs[11] = '{32'h301, 32'h0,        1'b0, 1'b1, 3'b000, 32'h00007F00, 2, 32'h0,        4'h2, 1'b0, 1'b0, 32'h0000007F};
    vecs[12] = '{32'h003, 32'h0,        1'b0, 1'b1, 3'b101, 32'h0,        1, 32'h0,        4'h0, 1'b0, 1'b1, 32'h0000007F};
    vecs[13] = '{32'h003, 32'h0,        1'b0, 1'b1, 3'b100, 32'hFF000000, 1, 32'h0,        4'h8, 1'b0, 1'b0, 32'h000000FF};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset mem_req", mem_req, 0);
    checkOutput("reset mem_we", mem_we, 0);
    checkOutput("reset mem_addr", mem_addr, 0);
    checkOutput("reset mem_wdata", mem_wdata, 0);
    checkOutput("reset mem_be", mem_be, 0);
    checkOutput("reset ReadDataM", ReadDataM, 0);
    checkOutput("reset StallM", StallM, 0);
    checkOutput("reset MisalignM", MisalignM, 0);

    rst_n = 1'b1;
    tick();
    checkOutput("no_access StallM", StallM, 0);
    checkOutput("no_access mem_req", mem_req, 0);
    checkOutput("no_access MisalignM", MisalignM, 0);

    for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);

    // Reset in the middle of an outstanding load must abandon it.
    ALUResultM = 32'h400;
    MemReadM   = 1'b1;
    AddrModeM  = 3'b010;
    #1;
    checkOutput("rst_seq issue StallM", StallM, 1);
    tick();
    checkOutput("rst_seq busy mem_req", mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_seq async mem_req", mem_req, 0);
    checkOutput("rst_seq async StallM", StallM, 0);
    checkOutput("rst_seq async ReadDataM", ReadDataM, 0);
    checkOutput("rst_seq async mem_addr", mem_addr, 0);
    mem_ready = 1'b1;
    mem_rdata = 32'h12345678;
    tick();
    rst_n    = 1'b1;
    MemReadM = 1'b0;
    tick();
    checkOutput("rst_seq late_ready mem_req", mem_req, 0);
    checkOutput("rst_seq late_ready StallM", StallM, 0);
    checkOutput("rst_seq late_ready ReadDataM", ReadDataM, 0);
    tick();
    checkOutput("rst_seq settled ReadDataM", ReadDataM, 0);
    clearInputs();
    tick();

    applyStimulus(vecs[2], 100);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
